// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port between N_REQ requesters.
// Issues a single DRP transaction at a time, with a watchdog for missing DRDY.
module xadc_drp_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [16*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 drp_den,
    output logic                 drp_dwe,
    output logic [6:0]           drp_daddr,
    output logic [15:0]          drp_di,
    input  logic                 drp_drdy,
    input  logic [15:0]          drp_do
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     rr_ptr, rr_ptr_n;
    logic [IW-1:0]     gnt, gnt_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              lat_we, lat_we_n;
    logic [6:0]        daddr_n;
    logic [15:0]       di_n;
    logic [N_REQ-1:0]  req_ready_n, rsp_valid_n;
    logic [15:0]       rsp_data_n;
    logic              rsp_err_n, busy_n, drp_den_n, drp_dwe_n;

    logic [6:0]        addr_arr  [N_REQ];
    logic [15:0]       wdata_arr [N_REQ];
    logic              found;
    logic [IW-1:0]     pick;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[7*g +: 7];
        assign wdata_arr[g] = req_wdata[16*g +: 16];
    end

    // Index arithmetic modulo N_REQ for any (non power-of-two) N_REQ.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    // Round-robin search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[wrap_add(rr_ptr, i)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_ptr, i);
            end
        end
    end

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        gnt_n       = gnt;
        cnt_n       = cnt;
        lat_we_n    = lat_we;
        daddr_n     = drp_daddr;
        di_n        = drp_di;
        req_ready_n = '0;
        rsp_valid_n = '0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        drp_den_n   = 1'b0;
        drp_dwe_n   = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n             = pick;
                    lat_we_n          = req_we[pick];
                    daddr_n           = addr_arr[pick];
                    di_n              = wdata_arr[pick];
                    req_ready_n[pick] = 1'b1;
                    drp_den_n         = 1'b1;
                    drp_dwe_n         = req_we[pick];
                    state_n           = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // DRDY takes precedence over an expiring watchdog.
                if (drp_drdy) begin
                    rsp_data_n       = lat_we ? 16'h0000 : drp_do;
                    rsp_err_n        = 1'b0;
                    rsp_valid_n[gnt] = 1'b1;
                    state_n          = RESP;
                end else if (cnt == CNT_LAST) begin
                    rsp_data_n       = 16'h0000;
                    rsp_err_n        = 1'b1;
                    rsp_valid_n[gnt] = 1'b1;
                    state_n          = RESP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RESP: begin
                rr_ptr_n = wrap_add(gnt, 1);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            drp_daddr <= '0;
            drp_di    <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            gnt       <= gnt_n;
            cnt       <= cnt_n;
            lat_we    <= lat_we_n;
            drp_daddr <= daddr_n;
            drp_di    <= di_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            busy      <= busy_n;
            drp_den   <= drp_den_n;
            drp_dwe   <= drp_dwe_n;
        end
    end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Scoreboard bench for xadc_drp_arbiter: a DRP responder model plus a
// round-robin grant model predict every grant and response.
module tb_xadc_drp_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned T = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_we;
    logic [7*N-1:0]  req_addr;
    logic [16*N-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [15:0]     rsp_data;
    logic            rsp_err, busy, drp_den, drp_dwe;
    logic [6:0]      drp_daddr;
    logic [15:0]     drp_di;
    logic            drp_drdy;
    logic [15:0]     drp_do;

    logic [6:0]      a_arr [N];
    logic [15:0]     d_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[7*g +: 7]    = a_arr[g];
        assign req_wdata[16*g +: 16] = d_arr[g];
    end

    xadc_drp_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
        .drp_di(drp_di), .drp_drdy(drp_drdy), .drp_do(drp_do)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0, cyc = 0;
    int          model_rr = 0, rsp_cnt = 0, last_idx = -1;
    int          drdy_dly = 0, dly_cnt = 0;
    logic        keep_valid = 1'b0;
    logic [15:0] do_val = 16'h0000;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int exp_grant(input logic [N-1:0] v, input int rr);
        for (int i = 0; i < int'(N); i++)
            if (v[(rr + i) % int'(N)]) return (rr + i) % int'(N);
        return -1;
    endfunction

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_data, rsp_err, busy,
                 drp_den, drp_dwe, drp_daddr, drp_di};
    endfunction

    task automatic set_req(input int i, input logic we, input logic [6:0] a, input logic [15:0] d);
        req_we[i]    = we;
        a_arr[i]     = a;
        d_arr[i]     = d;
        req_valid[i] = 1'b1;
    endtask

    // One clock: sample DUT at negedge, then update DRP responder and requesters.
    task automatic tick();
        exp_t e;
        int   g;
        @(negedge clk);
        cyc++;
        drp_drdy = 1'b0;
        drp_do   = do_val;
        if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) drp_drdy = 1'b1;
        end
        check("dwe_without_den", 32'(drp_dwe & ~drp_den), 32'(0));
        if (drp_den) begin
            g = exp_grant(req_valid, model_rr);
            check("grant", 32'(req_ready), (g < 0) ? 32'(0) : (32'(1) << g));
            if (g >= 0) begin
                check("dwe", 32'(drp_dwe), 32'(req_we[g]));
                check("daddr", 32'(drp_daddr), 32'(a_arr[g]));
                check("di", 32'(drp_di), 32'(d_arr[g]));
                e.idx  = g;
                e.err  = (drdy_dly == 0) || (drdy_dly > int'(T));
                e.data = (e.err || req_we[g]) ? 16'h0000 : do_val;
                e.cyc  = cyc + (e.err ? int'(T) : drdy_dly) + 1;
                sb.push_back(e);
                if (!keep_valid) req_valid[g] = 1'b0;
            end
            dly_cnt = drdy_dly;
        end else begin
            check("ready_without_den", 32'(req_ready), 32'(0));
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                model_rr = (e.idx + 1) % int'(N);
                last_idx = e.idx;
                rsp_cnt++;
            end
        end
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int t;
        t = 0;
        while (rsp_cnt < n && t < budget) begin
            tick();
            t++;
        end
        check("rsp_wait_budget", 32'(rsp_cnt >= n), 32'(1));
    endtask

    initial begin
        int prev, first;
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        drp_drdy  = 1'b0;
        drp_do    = '0;
        for (int i = 0; i < int'(N); i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
        repeat (3) tick();
        check("reset_outputs", 32'(any_out()), 32'(0));
        reset = 1'b0;
        tick();

        // Single read from requester 0, DRDY in 4th WAIT cycle.
        do_val   = 16'h9A30;
        drdy_dly = 4;
        set_req(0, 1'b0, 7'h00, 16'h0000);
        wait_rsp(rsp_cnt + 1, 40);

        // All requesters continuously valid: rotating grants.
        keep_valid = 1'b1;
        drdy_dly   = 1;
        do_val     = 16'h0BEE;
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, 7'(7'h10 + i), 16'h0000);
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(rsp_cnt + 1, 20);
            if (prev >= 0) check("rr_order", 32'(last_idx), 32'((prev + 1) % int'(N)));
            prev = last_idx;
        end
        req_valid  = '0;
        keep_valid = 1'b0;
        repeat (4) tick();
        check("sb_empty_rr", 32'(sb.size()), 32'(0));

        // Write from requester 2: read data must be masked to 0.
        drdy_dly = 3;
        do_val   = 16'hFFFF;
        set_req(2, 1'b1, 7'h41, 16'h2000);
        wait_rsp(rsp_cnt + 1, 40);

        // Timeout, then a stray DRDY after the abort.
        drdy_dly = 10;
        do_val   = 16'h5555;
        set_req(3, 1'b0, 7'h12, 16'h0000);
        wait_rsp(rsp_cnt + 1, 40);
        repeat (3) begin
            tick();
            check("busy_after_timeout", 32'(busy), 32'(0));
            check("no_rsp_after_timeout", 32'(rsp_valid), 32'(0));
        end

        // DRDY on the final WAIT cycle wins over the watchdog.
        drdy_dly = int'(T);
        do_val   = 16'h1234;
        set_req(2, 1'b0, 7'h03, 16'h0000);
        wait_rsp(rsp_cnt + 1, 40);
        repeat (3) tick();
        check("rsp_data_hold", 32'(rsp_data), 32'(16'h1234));

        // Reset during WAIT of requester 1.
        drdy_dly = 0;
        set_req(1, 1'b0, 7'h20, 16'h0000);
        for (int t = 0; t < 10 && sb.size() == 0; t++) tick();
        check("issue_before_reset", 32'(sb.size()), 32'(1));
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("reset_mid_outputs", 32'(any_out()), 32'(0));
        sb.delete();
        dly_cnt  = 0;
        model_rr = 0;
        repeat (2) tick();
        reset = 1'b0;
        drdy_dly = 2;
        do_val   = 16'h0777;
        set_req(1, 1'b0, 7'h20, 16'h0000);
        set_req(3, 1'b0, 7'h21, 16'h0000);
        wait_rsp(rsp_cnt + 1, 40);
        first = last_idx;
        check("first_after_reset", 32'(first), 32'(1));
        wait_rsp(rsp_cnt + 1, 40);
        check("second_after_reset", 32'(last_idx), 32'(3));
        repeat (3) tick();
        check("sb_empty_end", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
